// File: rtl/sum_display_driver.sv
// Converts a 5-bit adder sum to two BCD digits with a sequential double-dabble FSM
// and scans them onto a 2-digit common-anode 7-segment display with tens blanking.
module sum_display_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] sum,
    input  logic       load,
    output logic       ready,
    output logic [6:0] seg,
    output logic [1:0] an
);
    // state  | meaning
    // IDLE   | waiting for load, ready=1
    // CONV   | one double-dabble add-3/shift step per cycle, 5 steps
    // COMMIT | copy BCD scratch into the display registers
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    localparam int CW = $clog2(REFRESH_DIV);

    state_t        state_q, state_d;
    logic [4:0]    shift_q, shift_d;
    logic [7:0]    bcd_q, bcd_d, bcd_adj;
    logic [2:0]    iter_q, iter_d;
    logic [3:0]    disp_tens_q, disp_tens_d;
    logic [3:0]    disp_ones_q, disp_ones_d;
    logic [CW-1:0] refresh_q;
    logic          digit_sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bcd_q       <= '0;
            iter_q      <= '0;
            disp_tens_q <= '0;
            disp_ones_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bcd_q       <= bcd_d;
            iter_q      <= iter_d;
            disp_tens_q <= disp_tens_d;
            disp_ones_q <= disp_ones_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bcd_d       = bcd_q;
        iter_d      = iter_q;
        disp_tens_d = disp_tens_q;
        disp_ones_d = disp_ones_q;
        bcd_adj     = bcd_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    shift_d = sum;
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                // Tens stays below 5 for inputs up to 31, so only ones needs the add-3.
                if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
                bcd_d   = {bcd_adj[6:0], shift_q[4]};
                shift_d = {shift_q[3:0], 1'b0};
                iter_d  = iter_q + 3'd1;
                if (iter_q == 3'd4) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                disp_tens_d = bcd_q[7:4];
                disp_ones_d = bcd_q[3:0];
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ready = (state_q == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_q   <= '0;
            digit_sel_q <= 1'b0;
        end else if (refresh_q == CW'(REFRESH_DIV - 1)) begin
            refresh_q   <= '0;
            digit_sel_q <= ~digit_sel_q;
        end else begin
            refresh_q   <= refresh_q + CW'(1);
        end
    end

    function automatic logic [6:0] pattern(input logic [3:0] d);
        case (d)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        an  = 2'b10;
        seg = pattern(disp_ones_q);
        if (digit_sel_q) begin
            if (disp_tens_q != 4'd0) begin
                an  = 2'b01;
                seg = pattern(disp_tens_q);
            end else begin
                an  = 2'b11;
                seg = 7'b1111111;
            end
        end
    end
endmodule

// File: tb/tb_sum_display_driver.sv
// Directed bench for sum_display_driver with REFRESH_DIV=4: table vectors,
// ignored-load, reset-abort, reset-priority and a held-load sweep of 0..31.
module tb_sum_display_driver;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] sum;
    logic       load;
    logic       ready;
    logic [6:0] seg;
    logic [1:0] an;

    int n_checks = 0;
    int n_fail   = 0;

    sum_display_driver #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .sum   (sum),
        .load  (load),
        .ready (ready),
        .seg   (seg),
        .an    (an)
    );

    always #5 clk = ~clk;

    // Scan phase reference: digit select toggles every 4 cycles after reset.
    int   m_cnt;
    logic m_sel;
    always @(posedge clk) begin
        if (rst) begin
            m_cnt <= 0;
            m_sel <= 1'b0;
        end else if (m_cnt == 3) begin
            m_cnt <= 0;
            m_sel <= ~m_sel;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    typedef struct {
        logic [4:0] sum;
        logic [6:0] ones_seg;
        logic [6:0] tens_seg;
        logic [1:0] tens_an;
    } vec_t;

    vec_t       vecs[8];
    vec_t       v_zero, v_31, v_12;
    logic [6:0] pat[10];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] vec_exp(input vec_t v, input logic sel);
        return sel ? {v.tens_an, v.tens_seg} : {2'b10, v.ones_seg};
    endfunction

    function automatic logic [8:0] ref_exp(input int val, input logic sel);
        int t, o;
        t = val / 10;
        o = val % 10;
        if (!sel) return {2'b10, pat[o]};
        if (t == 0) return {2'b11, 7'b1111111};
        return {2'b01, pat[t]};
    endfunction

    task automatic check_scan(input string nm, input vec_t v);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk(nm, {an, seg}, vec_exp(v, m_sel));
        end
    endtask

    task automatic do_load(input vec_t v);
        @(negedge clk);
        sum  = v.sum;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        sum  = ~v.sum;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("ready_low", ready, 0);
        end
        @(negedge clk);
        chk("ready_high", ready, 1);
        chk("disp_immediate", {an, seg}, vec_exp(v, m_sel));
        check_scan("disp_scan", v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
        pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
        pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
        pat[9] = 7'b0010000;
        vecs[0] = '{5'd30, 7'b1000000, 7'b0110000, 2'b01};
        vecs[1] = '{5'd7,  7'b1111000, 7'b1111111, 2'b11};
        vecs[2] = '{5'd0,  7'b1000000, 7'b1111111, 2'b11};
        vecs[3] = '{5'd10, 7'b1000000, 7'b1111001, 2'b01};
        vecs[4] = '{5'd19, 7'b0010000, 7'b1111001, 2'b01};
        vecs[5] = '{5'd25, 7'b0010010, 7'b0100100, 2'b01};
        vecs[6] = '{5'd9,  7'b0010000, 7'b1111111, 2'b11};
        vecs[7] = '{5'd16, 7'b0000010, 7'b1111001, 2'b01};
        v_zero  = '{5'd0,  7'b1000000, 7'b1111111, 2'b11};
        v_31    = '{5'd31, 7'b1111001, 7'b0110000, 2'b01};
        v_12    = '{5'd12, 7'b0100100, 7'b1111001, 2'b01};

        rst  = 1'b1;
        load = 1'b0;
        sum  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_ready", ready, 1);
        chk("reset_ones", {an, seg}, {2'b10, 7'b1000000});
        repeat (4) @(negedge clk);
        chk("reset_tens_blank", {an, seg}, {2'b11, 7'b1111111});
        repeat (4) @(negedge clk);
        chk("reset_ones_again", {an, seg}, {2'b10, 7'b1000000});

        foreach (vecs[i]) do_load(vecs[i]);

        // Loads during conversion are dropped.
        @(negedge clk);
        sum  = 5'd31;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sum  = 5'd5;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("ign_ready_low", ready, 0);
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        chk("ign_ready_low6", ready, 0);
        @(negedge clk);
        chk("ign_ready_high", ready, 1);
        check_scan("ign_scan", v_31);

        // Reset mid-conversion clears the display back to 0.
        @(negedge clk);
        sum  = 5'd19;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", ready, 1);
        chk("abort_disp", {an, seg}, {2'b10, 7'b1000000});
        check_scan("abort_scan", v_zero);
        do_load(v_12);

        // Reset wins over a simultaneous load.
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b1;
        sum  = 5'd25;
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        chk("prio_ready", ready, 1);
        @(negedge clk);
        chk("prio_ready_next", ready, 1);
        check_scan("prio_scan", v_zero);

        // Held load: one acceptance every 7 cycles, sum scrambled during CONV.
        @(negedge clk);
        load = 1'b1;
        for (int v = 0; v < 32; v++) begin
            sum = 5'(v);
            chk("sweep_ready_high", ready, 1);
            @(posedge clk);
            #1 sum = ~5'(v);
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                chk("sweep_ready_low", ready, 0);
            end
            @(negedge clk);
            chk($sformatf("sweep_val%0d", v), {an, seg}, ref_exp(v, m_sel));
        end
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("sweep_final", {an, seg}, ref_exp(31, m_sel));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sum_display_driver.md
# sum_display_driver

Sits directly downstream of the 4-bit adder and consumes its 5-bit sum (0–31). On a load strobe it converts the value to two decimal digits with a sequential double-dabble FSM. It then drives a 2-digit, time-multiplexed, common-anode 7-segment display with tens-digit leading-zero blanking.

## Interface
- REFRESH_DIV, 100000: clock cycles each digit is displayed before the scan switches; legal range ≥ 2.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- sum  in  5  unsigned sum from the adder, sampled only when accepted.
- load  in  1  request to capture `sum`; accepted only when `ready`=1.
- ready  out  1  high when the FSM is idle and can accept `load`.
- seg  out  7  segment drive, active-low, seg[6:0] = {g,f,e,d,c,b,a}.
- an  out  2  digit enables, active-low; an[0] = ones digit, an[1] = tens digit.

## Operation
- FSM states: IDLE, CONV, COMMIT.
- IDLE:
  - `ready`=1.
  - When `load`=1, capture `sum` into a 5-bit shift register, clear the 8-bit BCD scratch ({tens[3:0], ones[3:0]}), clear the 3-bit iteration count, and go to CONV.
- CONV, once per cycle for exactly 5 cycles:
  - If ones ≥ 5, add 3 to ones. Tens never reaches 5 because the maximum is 31.
  - Then shift {BCD scratch, shift reg} left by 1.
  - After the 5th shift, go to COMMIT.
- COMMIT:
  - Copy the scratch into the display registers disp_tens and disp_ones.
  - Go to IDLE.
- `load` in CONV or COMMIT is ignored; no queueing.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, toggle `digit_sel` (0 = ones, 1 = tens).
  - Free-running and independent of the FSM.
- Output decode (combinational from `digit_sel`, disp_tens, disp_ones):
  - digit_sel=0: an=2'b10, seg=pattern(disp_ones).
  - digit_sel=1, disp_tens≠0: an=2'b01, seg=pattern(disp_tens).
  - digit_sel=1, disp_tens=0 (blanked): an=2'b11, seg=7'b1111111.
- Patterns, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A digit value >9 cannot occur; if it does, seg = 7'b1111111.

## Timing
- Reset, with `rst` sampled high:
  - state=IDLE, `ready`=1.
  - disp_tens=0, disp_ones=0.
  - Refresh counter=0, `digit_sel`=0.
  - Scratch and shift register cleared.
  - Outputs after reset: an=2'b10, seg=7'b1000000, so the display shows "0".
- `rst` has priority over `load` in the same cycle.
- Reset mid-conversion aborts the conversion and returns to the reset values. The display is cleared to 0, not left at the previous value.
- Load latency, with `load` accepted on edge E0:
  - CONV occupies edges E1–E5.
  - COMMIT occupies edge E6: display registers update and `ready` rises.
  - `ready` is low for the 6 cycles following E0.
- New seg/an values are visible immediately after E6, in the current scan phase. The commit does not reset the refresh counter.
- Back-to-back: a `load` held high is accepted again in the first cycle `ready`=1 after E6. The minimum accept interval is 7 cycles.
- Scan: `digit_sel` toggles every REFRESH_DIV cycles. The first toggle is REFRESH_DIV cycles after reset release.
- `sum` only needs to be stable in the accepting cycle. Changes during CONV have no effect.

## Test plan
- Reset, REFRESH_DIV=4 -> ready=1, an=2'b10, seg=7'b1000000. Four cycles later an=2'b11 and seg=7'b1111111 (tens blanked). Four cycles after that, back to the ones digit.
- load with sum=30 -> ready=0 for 6 cycles then 1. Ones phase shows seg=1000000 on an=10; tens phase shows seg=0110000 on an=01.
- load with sum=7 -> ones phase shows seg=1111000. Tens phase is blanked: an=11, seg=1111111.
- load with sum=31, then load pulses with sum=5 on cycles 2 and 4 of the conversion -> both later pulses ignored. The display shows "31": tens=0110000, ones=1111001.
- load with sum=19, then rst asserted 3 cycles later -> ready=1 and the display shows "0" on the cycle after reset. A subsequent load with sum=12 shows "12" 6 cycles after acceptance.
- load held continuously with sum stepping 0..31 -> each accepted value, one every 7 cycles, displays its correct decimal digits. Check against a reference model for all 32 values.
